// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues request-to-send, shifts
// one command byte out on device clock falls and checks the device ACK bit.
module ps2_host_tx #(
   parameter int CLK_FREQ   = 28_000_000,
   parameter int INHIBIT_US = 120,
   parameter int TIMEOUT_US = 15000,
   parameter int FILTER_LEN = 8
) (
   input  logic       clk28,
   input  logic       rst,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       busy,
   output logic       done,
   output logic       err,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe
);
   localparam int T_REQ = CLK_FREQ / 1_000_000;
   localparam int T_INH = T_REQ * INHIBIT_US;
   localparam int T_TO  = T_REQ * TIMEOUT_US;
   localparam int T_MAX = (T_TO > T_INH) ? T_TO : T_INH;
   localparam int TW    = $clog2(T_MAX + 1);
   localparam int FW    = $clog2(FILTER_LEN + 1);

   typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_REL} state_t;

   // Line conditioning: bit 0 = clock, bit 1 = data. Idle lines are pulled high.
   logic [1:0] raw;
   logic [1:0] filt;
   assign raw = {ps2_dat_in, ps2_clk_in};

   for (genvar gi = 0; gi < 2; gi++) begin : g_filt
      logic          s1_reg, s2_reg, f_reg;
      logic [FW-1:0] cnt_reg;
      always_ff @(posedge clk28) begin
         if (rst) begin
            s1_reg  <= 1'b1;
            s2_reg  <= 1'b1;
            f_reg   <= 1'b1;
            cnt_reg <= '0;
         end else begin
            s1_reg <= raw[gi];
            s2_reg <= s1_reg;
            if (s2_reg == f_reg) begin
               cnt_reg <= '0;
            end else if (cnt_reg == FW'(FILTER_LEN - 1)) begin
               f_reg   <= s2_reg;
               cnt_reg <= '0;
            end else begin
               cnt_reg <= cnt_reg + 1'b1;
            end
         end
      end
      assign filt[gi] = f_reg;
   end

   logic clk_f, dat_f, clk_f_d_reg, fall;
   assign clk_f = filt[0];
   assign dat_f = filt[1];
   assign fall  = clk_f_d_reg & ~clk_f;

   state_t        state_reg, state_next;
   logic [TW-1:0] timer_reg, timer_next;
   logic [9:0]    sh_reg, sh_next;
   logic [3:0]    n_reg, n_next;
   logic          dat_oe_reg, dat_oe_next;
   logic          done_reg, done_next;
   logic          err_reg, err_next;

   always_ff @(posedge clk28) begin
      if (rst) begin
         state_reg   <= IDLE;
         timer_reg   <= '0;
         sh_reg      <= '0;
         n_reg       <= '0;
         dat_oe_reg  <= 1'b0;
         done_reg    <= 1'b0;
         err_reg     <= 1'b0;
         clk_f_d_reg <= 1'b1;
      end else begin
         state_reg   <= state_next;
         timer_reg   <= timer_next;
         sh_reg      <= sh_next;
         n_reg       <= n_next;
         dat_oe_reg  <= dat_oe_next;
         done_reg    <= done_next;
         err_reg     <= err_next;
         clk_f_d_reg <= clk_f;
      end
   end

   always_comb begin
      state_next  = state_reg;
      timer_next  = timer_reg;
      sh_next     = sh_reg;
      n_next      = n_reg;
      dat_oe_next = dat_oe_reg;
      done_next   = 1'b0;
      err_next    = 1'b0;
      ps2_clk_oe  = 1'b0;
      case (state_reg)
         IDLE: begin
            dat_oe_next = 1'b0;
            if (tx_valid) begin
               sh_next    = {1'b1, ~^tx_data, tx_data};
               n_next     = '0;
               timer_next = '0;
               state_next = INHIBIT;
            end
         end
         INHIBIT: begin
            ps2_clk_oe = 1'b1;
            if (timer_reg == TW'(T_INH - 1)) begin
               timer_next  = '0;
               dat_oe_next = 1'b1;
               state_next  = REQ;
            end else begin
               timer_next = timer_reg + 1'b1;
            end
         end
         REQ: begin
            ps2_clk_oe = 1'b1;
            if (timer_reg == TW'(T_REQ - 1)) begin
               timer_next = '0;
               state_next = SHIFT;
            end else begin
               timer_next = timer_reg + 1'b1;
            end
         end
         SHIFT: begin
            timer_next = timer_reg + 1'b1;
            // Start bit is still held from REQ; each fall presents the next frame bit.
            if (fall) begin
               dat_oe_next = ~sh_reg[0];
               sh_next     = {1'b0, sh_reg[9:1]};
               n_next      = n_reg + 1'b1;
               if (n_reg == 4'd9) state_next = ACK;
            end
         end
         ACK: begin
            dat_oe_next = 1'b0;
            timer_next  = timer_reg + 1'b1;
            if (fall) begin
               n_next = n_reg + 1'b1;
               if (!dat_f) begin
                  state_next = WAIT_REL;
               end else begin
                  err_next   = 1'b1;
                  state_next = IDLE;
               end
            end
         end
         WAIT_REL: begin
            timer_next = timer_reg + 1'b1;
            if (clk_f && dat_f) begin
               done_next  = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      // The device owns the clock once released; give up if it stalls too long.
      if ((state_reg == SHIFT || state_reg == ACK || state_reg == WAIT_REL) &&
          timer_reg == TW'(T_TO - 1)) begin
         state_next  = IDLE;
         dat_oe_next = 1'b0;
         done_next   = 1'b0;
         err_next    = 1'b1;
      end
   end

   assign tx_ready   = (state_reg == IDLE);
   assign busy       = (state_reg != IDLE);
   assign done       = done_reg;
   assign err        = err_reg;
   assign ps2_dat_oe = dat_oe_reg;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a PS/2 device model that clocks frames,
// plus table-driven, random and corner-case sequences against a frame-level model.
`timescale 1ns/1ps
module tb_ps2_host_tx;
   localparam int CLK_FREQ   = 28_000_000;
   localparam int INHIBIT_US = 120;
   localparam int TIMEOUT_US = 200;
   localparam int FILTER_LEN = 8;
   localparam int T_REQ      = CLK_FREQ / 1_000_000;
   localparam int T_INH      = T_REQ * INHIBIT_US;
   localparam int T_TO       = T_REQ * TIMEOUT_US;
   localparam int H          = 40;

   logic       clk28 = 1'b0;
   logic       rst = 1'b1;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_ready, busy, done, err, ps2_clk_oe, ps2_dat_oe;
   logic       dev_clk = 1'b1;
   logic       dev_dat = 1'b1;
   logic       ps2_clk_in, ps2_dat_in;

   assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
   assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

   ps2_host_tx #(
      .CLK_FREQ(CLK_FREQ), .INHIBIT_US(INHIBIT_US),
      .TIMEOUT_US(TIMEOUT_US), .FILTER_LEN(FILTER_LEN)
   ) dut (
      .clk28(clk28), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
      .tx_ready(tx_ready), .busy(busy), .done(done), .err(err),
      .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
      .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe)
   );

   always #18 clk28 = ~clk28;

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt = 0;
   int err_cnt  = 0;
   int both_cnt = 0;

   always @(posedge clk28) begin
      if (done) done_cnt <= done_cnt + 1;
      if (err) err_cnt <= err_cnt + 1;
      if (done && err) both_cnt <= both_cnt + 1;
   end

   typedef struct {
      logic [7:0] data;
      bit         ack;
      int         exp_done;
      int         exp_err;
   } vec_t;

   task automatic tick(input int n);
      repeat (n) @(negedge clk28);
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Issue a byte and time the inhibit / request phases up to clock release.
   task automatic start_frame(input logic [7:0] d, input bit poke);
      int c;
      check("ready_before", int'(tx_ready), 1);
      tx_data  = d;
      tx_valid = 1'b1;
      tick(1);
      tx_valid = 1'b0;
      check("busy_after_accept", int'(busy), 1);
      c = 0;
      while (ps2_clk_oe && !ps2_dat_oe && c < T_INH + 100) begin
         if (poke && c == 10) begin tx_valid = 1'b1; tx_data = ~d; end
         if (poke && c == 14) begin tx_valid = 1'b0; tx_data = d; end
         c++;
         tick(1);
      end
      check("inhibit_cycles", c, T_INH);
      c = 0;
      while (ps2_clk_oe && ps2_dat_oe && c < T_REQ + 100) begin
         c++;
         tick(1);
      end
      check("req_cycles", c, T_REQ);
      check("start_bit_held", int'(ps2_dat_oe), 1);
      check("clk_released", int'(ps2_clk_oe), 0);
   endtask

   // Device model: 11 clock pulses, ACK (or not) on the 11th, optional reset at a fall.
   task automatic do_frame(input logic [7:0] d, input bit ack, input int exp_done,
                           input int exp_err, input int abort_at, input bit glitch);
      int d0, e0, b0, c, expb, line;
      d0 = done_cnt; e0 = err_cnt; b0 = both_cnt;
      start_frame(d, glitch);
      tick(5);
      if (glitch) begin
         dev_clk = 1'b0; tick(3); dev_clk = 1'b1; tick(20);
         check("glitch_no_advance", int'(ps2_dat_oe), 1);
      end
      for (int k = 1; k <= 11; k++) begin
         if (k == 11) dev_dat = ack ? 1'b0 : 1'b1;
         tick(H / 2);
         dev_clk = 1'b0;
         tick(H - 2);
         if (k == abort_at) begin
            rst = 1'b1; tick(1); rst = 1'b0;
            check("rst_clk_oe", int'(ps2_clk_oe), 0);
            check("rst_dat_oe", int'(ps2_dat_oe), 0);
            check("rst_busy", int'(busy), 0);
            check("rst_ready", int'(tx_ready), 1);
            dev_clk = 1'b1; dev_dat = 1'b1;
            tick(H);
            check("rst_no_done", done_cnt - d0, 0);
            check("rst_no_err", err_cnt - e0, 0);
            return;
         end
         if (k <= 10) begin
            if (k <= 8) expb = int'(d[k-1]);
            else if (k == 9) expb = (($countones(d) % 2) == 0) ? 1 : 0;
            else expb = 1;
            line = ps2_dat_oe ? 0 : 1;
            check($sformatf("bit%0d_of_%02h", k, d), line, expb);
         end
         tick(2);
         dev_clk = 1'b1;
         tick(H / 2);
      end
      tick(H / 2);
      dev_dat = 1'b1;
      c = 0;
      while (done_cnt == d0 && err_cnt == e0 && c < 500) begin
         c++;
         tick(1);
      end
      tick(3);
      check($sformatf("done_pulses_%02h", d), done_cnt - d0, exp_done);
      check($sformatf("err_pulses_%02h", d), err_cnt - e0, exp_err);
      check("done_err_overlap", both_cnt - b0, 0);
      check("ready_after", int'(tx_ready), 1);
      check("busy_after", int'(busy), 0);
      check("clk_oe_after", int'(ps2_clk_oe), 0);
      check("dat_oe_after", int'(ps2_dat_oe), 0);
      tick(50);
   endtask

   initial begin
      vec_t vecs[4];
      logic [7:0] rd;
      bit ra;
      int d0, e0, c;

      vecs[0] = '{8'hED, 1'b1, 1, 0};
      vecs[1] = '{8'hF4, 1'b1, 1, 0};
      vecs[2] = '{8'hFF, 1'b0, 0, 1};
      vecs[3] = '{8'h00, 1'b1, 1, 0};

      tick(3);
      check("reset_ready", int'(tx_ready), 1);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      check("reset_err", int'(err), 0);
      check("reset_clk_oe", int'(ps2_clk_oe), 0);
      check("reset_dat_oe", int'(ps2_dat_oe), 0);
      rst = 1'b0;
      tick(20);

      for (int i = 0; i < 4; i++)
         do_frame(vecs[i].data, vecs[i].ack, vecs[i].exp_done, vecs[i].exp_err, 0, 1'b0);

      for (int i = 0; i < 3; i++) begin
         rd = 8'($urandom_range(0, 255));
         ra = 1'($urandom_range(0, 1));
         do_frame(rd, ra, ra ? 1 : 0, ra ? 0 : 1, 0, 1'b0);
      end

      // Reset in the middle of a frame, then a clean frame.
      do_frame(8'hED, 1'b1, 0, 0, 5, 1'b0);
      tick(50);
      do_frame(8'h01, 1'b1, 1, 0, 0, 1'b0);

      // Short clock glitch plus a request while busy.
      do_frame(8'hA5, 1'b1, 1, 0, 0, 1'b1);

      // Device never clocks: timeout counted from clock release.
      d0 = done_cnt; e0 = err_cnt;
      start_frame(8'h00, 1'b0);
      c = 0;
      while (!err && c < T_TO + 100) begin
         tick(1);
         c++;
      end
      check("timeout_cycles", c, T_TO);
      tick(2);
      check("timeout_err", err_cnt - e0, 1);
      check("timeout_no_done", done_cnt - d0, 0);
      check("timeout_clk_oe", int'(ps2_clk_oe), 0);
      check("timeout_dat_oe", int'(ps2_dat_oe), 0);
      check("timeout_ready", int'(tx_ready), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
